// File: rtl/imem_loader_if.sv
// Stream-in / memory-write bundle for the instruction memory loader.
interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8
);
  logic                     start;
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic                     cpu_rst;

  // host / stream source side
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_rst
  );

  // loader side
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_rst
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a 16-bit little-endian length, that many image bytes and
// an XOR checksum byte from a valid/ready stream, writes the image to
// instruction memory at byte addresses 0..length-1 and releases the CPU reset
// only when the checksum matches.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // largest legal image: the whole loadable region, held in 17 bits
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDRESS_WIDTH);

  state_t                   state, next;
  logic [15:0]              length;
  logic [15:0]              cnt;
  logic [DATA_WIDTH-1:0]    csum;
  logic                     wr_en_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic                     ready;
  logic                     xfer;
  logic [15:0]              len_full;

  assign xfer     = bus.rx_valid & ready;
  // full length as it will be once the high byte is taken this cycle
  assign len_full = {bus.rx_data[7:0], length[7:0]};

  // state register; reset aborts any session at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // next-state: start only matters when no session is running
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (bus.start) next = S_LEN_LO;
      S_LEN_LO: if (xfer) next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if ({1'b0, len_full} > MAX_LEN) next = S_ERROR;
          else if (len_full == 16'd0)     next = S_CHECK;
          else                            next = S_LOAD;
        end
      end
      S_LOAD:   if (xfer && cnt == length - 16'd1) next = S_CHECK;
      S_CHECK:  if (xfer) next = (bus.rx_data == csum) ? S_DONE : S_ERROR;
      default:  next = S_IDLE;
    endcase
  end

  // status outputs decoded purely from the state register
  always_comb begin
    ready       = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.error   = 1'b0;
    bus.cpu_rst = 1'b1;
    case (state)
      S_LEN_LO, S_LEN_HI, S_LOAD, S_CHECK: begin
        ready    = 1'b1;
        bus.busy = 1'b1;
      end
      S_DONE:  begin bus.done = 1'b1; bus.cpu_rst = 1'b0; end
      S_ERROR: bus.error = 1'b1;
      default: ;
    endcase
  end

  // datapath: length capture, byte counter, running checksum, write register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      length    <= '0;
      cnt       <= '0;
      csum      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            cnt  <= '0;
            csum <= '0;
          end
        end
        S_LEN_LO: if (xfer) length[7:0]  <= bus.rx_data[7:0];
        S_LEN_HI: if (xfer) length[15:8] <= bus.rx_data[7:0];
        S_LOAD: begin
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt[ADDRESS_WIDTH-1:0];
            wr_data_q <= bus.rx_data;
            cnt       <= cnt + 16'd1;
            csum      <= csum ^ bus.rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized streams against a session-level model.
module tb_imem_loader;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int MAXL = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // session model: phase 0 idle, 1 active, 2 done, 3 error
  int         ph = 0;
  int         acc = 0;
  int         mlen = 0;
  logic [7:0] mx = '0;
  bit         pend = 0;
  int         paddr = 0;
  logic [7:0] pdata = '0;
  int         wcnt = 0;
  int         last_addr = -1;
  int         wlog_a [0:7];
  logic [7:0] wlog_d [0:7];
  logic [7:0] b;

  // compare DUT against the model, then advance the model by what the next edge will do
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
      chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
      chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_done",     32'(bus.done),     32'd0);
      chk("rst_error",    32'(bus.error),    32'd0);
      chk("rst_cpu_rst",  32'(bus.cpu_rst),  32'd1);
      ph   = 0;
      pend = 0;
    end else begin
      chk("wr_en", 32'(bus.wr_en), 32'(pend));
      if (pend) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(paddr));
        chk("wr_data", 32'(bus.wr_data), 32'(pdata));
        if (wcnt < 8) begin
          wlog_a[wcnt] = int'(bus.wr_addr);
          wlog_d[wcnt] = bus.wr_data;
        end
        last_addr = int'(bus.wr_addr);
        wcnt++;
      end
      chk("rx_ready", 32'(bus.rx_ready), 32'(ph == 1));
      chk("busy",     32'(bus.busy),     32'(ph == 1));
      chk("done",     32'(bus.done),     32'(ph == 2));
      chk("error",    32'(bus.error),    32'(ph == 3));
      chk("cpu_rst",  32'(bus.cpu_rst),  32'(ph != 2));
      pend = 0;
      if (ph != 1) begin
        if (bus.start) begin
          ph = 1; acc = 0; mx = '0; mlen = 0; wcnt = 0; last_addr = -1;
        end
      end else if (bus.rx_valid) begin
        b = bus.rx_data;
        if (acc == 0) mlen = int'(b);
        else if (acc == 1) begin
          mlen = mlen + int'(b) * 256;
          if (mlen > MAXL) ph = 3;
        end else if (acc - 2 < mlen) begin
          pend = 1; paddr = acc - 2; pdata = b; mx = mx ^ b;
        end else ph = (b == mx) ? 2 : 3;
        acc++;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  // offer each byte until taken; valid asserted with probability pct percent
  task automatic send(input logic [7:0] q[$], input int pct);
    foreach (q[i]) begin
      int guard = 0;
      forever begin
        @(posedge clk); #1;
        bus.rx_valid = ($urandom_range(99) < pct);
        bus.rx_data  = q[i];
        @(negedge clk);
        if (bus.rx_valid && bus.rx_ready) break;
        guard++;
        if (guard > 200) begin
          n_checks++; n_err++;
          $display("FAIL send_timeout: byte %0d not taken, rx_ready %0b expected 1", i, bus.rx_ready);
          @(posedge clk); #1 bus.rx_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk); #1 bus.rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;
    int len;
    bit good;
    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_reset_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("lit_reset_busy",    32'(bus.busy),    32'd0);
    rst = 1'b0;

    // 4-byte image with matching checksum
    do_start();
    s = {8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    send(s, 100);
    repeat (2) @(posedge clk); #1;
    chk("t1_done",    32'(bus.done),    32'd1);
    chk("t1_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    chk("t1_wcnt",    32'(wcnt),        32'd4);
    chk("t1_w0", {wlog_a[0][15:0], 8'h0, wlog_d[0]}, {16'd0, 8'h0, 8'h13});
    chk("t1_w1", {wlog_a[1][15:0], 8'h0, wlog_d[1]}, {16'd1, 8'h0, 8'h05});
    chk("t1_w2", {wlog_a[2][15:0], 8'h0, wlog_d[2]}, {16'd2, 8'h0, 8'hA0});
    chk("t1_w3", {wlog_a[3][15:0], 8'h0, wlog_d[3]}, {16'd3, 8'h0, 8'h00});

    // checksum mismatch
    do_start();
    s = {8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
    send(s, 70);
    repeat (2) @(posedge clk); #1;
    chk("t2_error",   32'(bus.error),   32'd1);
    chk("t2_done",    32'(bus.done),    32'd0);
    chk("t2_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("t2_wcnt",    32'(wcnt),        32'd2);

    // oversize length 4097
    do_start();
    s = {8'h01, 8'h10};
    send(s, 100);
    repeat (3) @(posedge clk); #1;
    chk("t3_error",    32'(bus.error),    32'd1);
    chk("t3_wcnt",     32'(wcnt),         32'd0);
    chk("t3_rx_ready", 32'(bus.rx_ready), 32'd0);

    // zero-length image, then restart out of DONE
    do_start();
    s = {8'h00, 8'h00, 8'h00};
    send(s, 100);
    repeat (2) @(posedge clk); #1;
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_wcnt", 32'(wcnt),     32'd0);
    do_start();
    chk("t4_restart_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("t4_restart_done",    32'(bus.done),    32'd0);
    chk("t4_restart_busy",    32'(bus.busy),    32'd1);

    // full 4096-byte image into the session just started, gappy valid
    s = {8'h00, 8'h10};
    x = '0;
    for (int i = 0; i < MAXL; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      s.push_back(r);
      x = x ^ r;
    end
    s.push_back(x);
    send(s, 60);
    repeat (2) @(posedge clk); #1;
    chk("t5_done",      32'(bus.done),  32'd1);
    chk("t5_wcnt",      32'(wcnt),      32'd4096);
    chk("t5_last_addr", 32'(last_addr), 32'hFFF);

    // random short sessions, some oversize, some bad checksum
    for (int n = 0; n < 8; n++) begin
      len  = ($urandom_range(4) == 0) ? 4097 + int'($urandom_range(3000)) : int'($urandom_range(12));
      good = $urandom_range(1);
      do_start();
      s = {8'(len), 8'(len >> 8)};
      x = '0;
      if (len <= MAXL) begin
        for (int i = 0; i < len; i++) begin
          logic [7:0] r;
          r = 8'($urandom);
          s.push_back(r);
          x = x ^ r;
        end
        s.push_back(good ? x : (x ^ 8'h5A));
      end
      send(s, 75);
      repeat (2) @(posedge clk); #1;
      chk("rnd_done",  32'(bus.done), 32'(len <= MAXL && good));
      chk("rnd_wcnt",  32'(wcnt),     32'(len <= MAXL ? len : 0));
    end

    // start while busy is ignored; async reset mid-load drops pending write
    do_start();
    s = {8'h04, 8'h00, 8'h11};
    send(s, 100);
    do_start();
    chk("t6_busy_after_start", 32'(bus.busy), 32'd1);
    s = {8'h22};
    bus.rx_valid = 1'b1; bus.rx_data = 8'h22;
    @(negedge clk);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    chk("t6_pending_wr_en",   32'(bus.wr_en),   32'd1);
    chk("t6_pending_wr_addr", 32'(bus.wr_addr), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_wr_en",    32'(bus.wr_en),    32'd0);
    chk("t6_async_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("t6_async_wr_data",  32'(bus.wr_data),  32'd0);
    chk("t6_async_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("t6_async_busy",     32'(bus.busy),     32'd0);
    chk("t6_async_cpu_rst",  32'(bus.cpu_rst),  32'd1);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t6_idle_busy",  32'(bus.busy),  32'd0);
    chk("t6_idle_error", 32'(bus.error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 12, width of wr_addr; loadable region is 2**ADDRESS_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 8, width of one memory byte and one stream byte.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_data  input  DATA_WIDTH  incoming stream byte.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
REQ-009 wr_en  output  1  byte write strobe to instruction memory.
REQ-010 wr_addr  output  ADDRESS_WIDTH  byte address of the write.
REQ-011 wr_data  output  DATA_WIDTH  byte to write.
REQ-012 busy  output  1  session in progress (any state except IDLE, DONE, ERROR).
REQ-013 done  output  1  image loaded and checksum matched.
REQ-014 error  output  1  session failed (oversize length or checksum mismatch).
REQ-015 cpu_rst  output  1  holds the CPU in reset; 0 only in DONE.

Function
REQ-016 States: IDLE, LEN_LO, LEN_HI, LOAD, CHECK, DONE, ERROR; state register is the only source of rx_ready/busy/done/error/cpu_rst.
REQ-017 IDLE, DONE, ERROR: start=1 -> LEN_LO next cycle, byte counter and running checksum cleared to 0; otherwise hold.
REQ-018 start is ignored in LEN_LO, LEN_HI, LOAD, CHECK.
REQ-019 rx_ready = 1 exactly in LEN_LO, LEN_HI, LOAD, CHECK; 0 elsewhere; no bytes consumed outside these states.
REQ-020 LEN_LO: accepted byte -> length[7:0], go LEN_HI. LEN_HI: accepted byte -> length[15:8].
REQ-021 On LEN_HI transfer: length > 2**ADDRESS_WIDTH -> ERROR; length == 0 -> CHECK; else -> LOAD.
REQ-022 LOAD: each accepted byte k (k = 0..length-1) produces wr_en=1, wr_addr=k, wr_data=byte in the following cycle (1-cycle registered latency); wr_en=0 in all other cycles.
REQ-023 Byte placement is little-endian by address: stream byte k lands at address k, so byte 4n is the LSB of instruction word n.
REQ-024 Running checksum = XOR of all LOAD bytes, updated on each LOAD transfer.
REQ-025 Transfer of byte length-1 moves LOAD -> CHECK; rx_valid=0 stalls any state without change.
REQ-026 CHECK: accepted byte == running checksum -> DONE; else -> ERROR.
REQ-027 DONE: done=1, cpu_rst=0, error=0. ERROR: error=1, cpu_rst=1, done=0. Both held until start or rst.
REQ-028 cpu_rst = 1 in all states except DONE; leaving DONE via start asserts cpu_rst the next cycle.
REQ-029 Length exactly 2**ADDRESS_WIDTH is legal; final write at address 2**ADDRESS_WIDTH-1, counter never wraps.
REQ-030 Length and counter are 16-bit internally; wr_addr is counter[ADDRESS_WIDTH-1:0].

Reset
REQ-031 rst=1 forces IDLE immediately regardless of clk, aborting any session.
REQ-032 Reset values: rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_rst=1; length, counter, checksum = 0.
REQ-033 A write pending from the last pre-reset transfer is dropped (wr_en=0 after reset).

Verification
REQ-034 start; stream 04 00, 13 05 A0 00, checksum B6 -> writes 0:13,1:05,2:A0,3:00 each one cycle after transfer; done=1, cpu_rst=0.
REQ-035 start; stream 02 00, AA 55, checksum 00 -> two writes, then error=1, done=0, cpu_rst=1.
REQ-036 start; stream 01 10 (4097) -> ERROR after LEN_HI, no wr_en pulse, rx_ready=0.
REQ-037 start; stream 00 00, 00 -> DONE with zero writes; then start -> cpu_rst=1, done=0 next cycle.
REQ-038 rx_valid toggled randomly during a 4096-byte load -> exactly 4096 writes, addresses 0..4095 in order, last at FFF, done=1.
REQ-039 rst asserted mid-LOAD (after 2 of 4 bytes) -> all outputs at reset values without clock edge; start while busy ignored.
